instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Holds the PC and issues word-aligned byte addresses to the synchronous instruction memory, which has 1-cycle read latency.
- Captures the returned instructions into a small in-order fetch buffer and presents them to decode with a valid/ready handshake.
- Supports branch/jump redirect, which flushes everything fetched on the old path.

Parameters:
- RESET_PC, 32'h0000_0000: PC after reset; bits [1:0] must be 0.
- DEPTH, 2: fetch buffer entries; power of 2, minimum 2.
- ADDR_W, 32: PC and address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- imem_addr  out  ADDR_W  byte address to instruction memory; equals the PC register.
- imem_rd_en  out  1  request issued this cycle; memory latches imem_addr at the next rising edge.
- imem_data  in  32  instruction for the request issued in the previous cycle.
- redirect_valid  in  1  branch/jump taken; has priority over all other activity.
- redirect_pc  in  ADDR_W  target address; bits [1:0] are ignored and forced to 0.
- inst_valid  out  1  head of the buffer is valid.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  head instruction.
- inst_pc  out  ADDR_W  address of the head instruction.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - PC = RESET_PC; buffer count = 0; in-flight flag = 0; read/write pointers = 0.
  - inst_valid = 0, inst_data = 0, inst_pc = 0.
  - imem_rd_en is held at 0 while reset = 0.
- Dequeue: occurs when inst_valid && inst_ready.
  - Head pointer advances.
  - inst_valid/inst_data/inst_pc are driven from the buffer head; no combinational path from imem_data to the inst_* outputs.
- Issue: imem_rd_en = !redirect_valid && (count + inflight − deq) < DEPTH.
  - On issue, at the clock edge: PC <= PC + 4 (modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0), inflight <= 1, and the request PC is stored as req_pc.
  - With no issue: inflight <= 0.
- Response: in any cycle with inflight = 1 and no redirect_valid, {imem_data, req_pc} is written to the tail at the clock edge and count increments.
  - Simultaneous write and dequeue leave count unchanged.
  - The issue rule guarantees a free slot, so a write never finds the buffer full; the bench asserts this.
- Redirect (redirect_valid = 1 in cycle T), at the T edge:
  - PC <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - count <= 0 and pointers cleared.
  - inflight <= 0; the response present in cycle T is discarded.
  - No issue in cycle T.
  - A dequeue handshake in cycle T still completes for the current head, so decode must itself ignore that instruction if it is younger than the branch.
- Redirect latency:
  - Target issued in T+1.
  - Data returned in T+2.
  - inst_valid = 1 with inst_pc = target in T+3.
- Reset-release latency:
  - First cycle after release: issue RESET_PC.
  - inst_valid rises 2 cycles later.
- Steady-state throughput with inst_ready held at 1: one instruction per cycle for any DEPTH ≥ 2.
- Backpressure (inst_ready = 0):
  - The buffer fills to DEPTH, then issue stops.
  - PC holds at the next unfetched address.
  - No instruction is lost or duplicated.
- Ordering: inst_pc values across accepted handshakes increase by 4, except across a redirect.

Test Plan:
- Memory model preloaded with word k = 0x1000_0000+k; release reset with inst_ready = 1 → inst_valid first rises at cycle 2; inst_pc = 0, 4, 8, … with one instruction per cycle and inst_data matching.
- inst_ready = 0 for 10 cycles after the first valid → count reaches 2, imem_rd_en = 0, PC holds at 0x8. Raise inst_ready → PCs 0x0, 0x4, 0x8 delivered in order with no gaps or duplicates.
- redirect_valid with redirect_pc = 0x40 while one request is in flight and the buffer is half full → the in-flight data is never presented; the next accepted inst_pc is 0x40, arriving 3 cycles after the redirect.
- redirect_pc = 0x47 → imem_addr = 0x44 in the next cycle; inst_pc = 0x44.
- Redirect to 0xFFFF_FFF8 with streaming → inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert reset for one cycle mid-stream with the buffer full → inst_valid drops immediately (asynchronously); after release, fetch restarts at RESET_PC with no stale entries.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit_if
// Bus bundle between the fetch unit, the instruction memory, the branch
// redirect source and decode.
// Revision: 1.0
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  // Instruction memory request/response
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [31:0]       imem_data;
  // Branch/jump redirect
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  // Decode handshake
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;

  // Fetch unit side
  modport master (
    output imem_addr, imem_rd_en, inst_valid, inst_data, inst_pc,
    input  imem_data, redirect_valid, redirect_pc, inst_ready
  );

  // Environment side (memory, branch unit, decode)
  modport slave (
    input  imem_addr, imem_rd_en, inst_valid, inst_data, inst_pc,
    output imem_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit
// Holds the PC, issues word-aligned reads to a 1-cycle-latency instruction
// memory, buffers returned words in order and hands them to decode with a
// valid/ready handshake. A redirect flushes everything on the old path.
// Revision: 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,   // asynchronous, active-low
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;

  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];

  logic              valid;
  logic              deq;
  logic              issue;
  logic              wr_en;
  logic [OCC_W-1:0]  occ;
  logic [ADDR_W-1:0] target;

  // Head of buffer drives decode directly; memory data only reaches decode
  // after it has been written into the buffer.
  assign valid          = (count_q != '0);
  assign bus.inst_valid = valid;
  assign bus.inst_data  = data_q[rptr_q];
  assign bus.inst_pc    = tag_q[rptr_q];
  assign bus.imem_addr  = pc_q;
  assign bus.imem_rd_en = issue;

  // Handshake decode, issue throttling and next-state computation
  always_comb begin
    deq    = valid && bus.inst_ready;
    // Slots that will be occupied after this cycle if nothing new is issued;
    // issuing is allowed only while that leaves room for the response.
    occ    = {1'b0, count_q} + OCC_W'(inflight_q) - OCC_W'(deq);
    // Gated by reset so no request escapes while the unit is held in reset.
    issue  = reset && !bus.redirect_valid && (occ < OCC_W'(DEPTH));
    wr_en  = inflight_q && !bus.redirect_valid;
    target = bus.redirect_pc & ~ADDR_W'(3);

    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;

    if (bus.redirect_valid) begin
      // Flush: the in-flight response and all buffered entries are dropped.
      pc_d    = target;
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + ADDR_W'(4);
        req_pc_d   = pc_q;
        inflight_d = 1'b1;
      end
      if (wr_en) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (deq) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (wr_en && !deq) begin
        count_d = count_q + CNT_W'(1);
      end else if (!wr_en && deq) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Fetch buffer storage; cleared on reset so decode sees zeros while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (wr_en) begin
      data_q[wptr_q] <= bus.imem_data;
      tag_q[wptr_q]  <= req_pc_q;
    end
  end

endmodule
`default_nettype wire
